// File: rtl/usb_tx_engine_pkg.sv
// Shared types and line constants for the USB transmit engine.
package usb_tx_engine_pkg;

  typedef struct packed {
    logic dp;
    logic dn;
  } d_port_t;

  localparam d_port_t J_FS = 2'b10;
  localparam d_port_t K_FS = 2'b01;
  localparam d_port_t J_LS = 2'b01;
  localparam d_port_t K_LS = 2'b10;
  localparam d_port_t SE0  = 2'b00;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_GAP
  } tx_state_t;

  // Maps the NRZI line level (k=1 means K) to pin values for the given speed.
  function automatic d_port_t line_sym(input logic low_spd, input logic k);
    if (low_spd) return k ? K_LS : J_LS;
    return k ? K_FS : J_FS;
  endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// Synchronous byte FIFO; a write into a full FIFO is taken when a pop happens in the same cycle.
module usb_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic [7:0] rd_data,
  input  logic       rd_en,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/usb_tx_engine.sv
// USB transmit path: byte FIFO, SYNC, bit stuffing, NRZI and EOP onto the D+/D- drivers.
module usb_tx_engine #(
  parameter int unsigned FS_DIV     = 2,
  parameter int unsigned LS_DIV     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDLE_BITS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       low_speed,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic [1:0] d_o,
  output logic       d_en,
  output logic       busy
);

  import usb_tx_engine_pkg::*;

  localparam int unsigned MAX_DIV = (LS_DIV > FS_DIV) ? LS_DIV : FS_DIV;
  localparam int unsigned TW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
  localparam int unsigned SW      = $clog2(IDLE_BITS + 2);
  localparam logic [TW-1:0] FS_LOAD = TW'(FS_DIV - 1);
  localparam logic [TW-1:0] LS_LOAD = TW'(LS_DIV - 1);

  tx_state_t     state;
  logic          ls;
  logic [TW-1:0] timer;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [2:0]    ones;
  logic          line_k;
  logic [SW-1:0] sym_left;
  d_port_t       d_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rd_data;
  logic          sym_end;
  logic [TW-1:0] reload;

  logic          stuff_now;
  logic          eop_now;
  logic          pop;
  logic          nxt_bit;
  logic          nxt_k;
  logic [7:0]    shift_nxt;
  logic [2:0]    bit_cnt_nxt;
  logic [2:0]    ones_nxt;

  assign ready   = !fifo_full && !reset;
  assign d_o     = d_q;
  assign sym_end = (timer == '0);
  assign reload  = ls ? LS_LOAD : FS_LOAD;

  usb_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (data),
    .wr_en   (valid && ready),
    .full    (fifo_full),
    .rd_data (fifo_rd_data),
    .rd_en   (pop),
    .empty   (fifo_empty)
  );

  // Next symbol selection: stuff bit beats data; at a byte boundary pop or end the packet.
  always_comb begin
    stuff_now   = (ones == STUFF_LIMIT);
    eop_now     = 1'b0;
    pop         = 1'b0;
    nxt_bit     = 1'b0;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    ones_nxt    = '0;
    if (stuff_now) begin
      nxt_bit = 1'b0;
    end else if (bit_cnt != '0) begin
      nxt_bit     = shift[0];
      shift_nxt   = {1'b0, shift[7:1]};
      bit_cnt_nxt = bit_cnt - 3'd1;
    end else if (!fifo_empty) begin
      nxt_bit     = fifo_rd_data[0];
      shift_nxt   = {1'b0, fifo_rd_data[7:1]};
      bit_cnt_nxt = 3'd7;
      pop         = sym_end && ((state == ST_SYNC) || (state == ST_DATA));
    end else begin
      eop_now = 1'b1;
    end
    if (!stuff_now && nxt_bit) ones_nxt = ones + 3'd1;
    nxt_k = nxt_bit ? line_k : !line_k;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ls       <= 1'b0;
      timer    <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      ones     <= '0;
      line_k   <= 1'b0;
      sym_left <= '0;
      d_q      <= J_FS;
      d_en     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (state != ST_IDLE) timer <= sym_end ? reload : timer - TW'(1);
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            // First SYNC bit (a 0) goes out on entry: toggle from J to K.
            ls      <= low_speed;
            timer   <= low_speed ? LS_LOAD : FS_LOAD;
            shift   <= {1'b0, SYNC_PATTERN[7:1]};
            bit_cnt <= 3'd7;
            ones    <= '0;
            line_k  <= 1'b1;
            d_q     <= line_sym(low_speed, 1'b1);
            d_en    <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_SYNC;
          end
        end
        ST_SYNC, ST_DATA: begin
          if (sym_end) begin
            if (eop_now) begin
              state    <= ST_EOP_SE0;
              d_q      <= SE0;
              sym_left <= SW'(1);
            end else begin
              line_k  <= nxt_k;
              d_q     <= line_sym(ls, nxt_k);
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt_nxt;
              ones    <= ones_nxt;
              if (pop) state <= ST_DATA;
            end
          end
        end
        ST_EOP_SE0: begin
          if (sym_end) begin
            if (sym_left != '0) begin
              sym_left <= sym_left - SW'(1);
            end else begin
              state  <= ST_EOP_J;
              line_k <= 1'b0;
              d_q    <= line_sym(ls, 1'b0);
            end
          end
        end
        ST_EOP_J: begin
          if (sym_end) begin
            state    <= ST_GAP;
            d_en     <= 1'b0;
            sym_left <= SW'(IDLE_BITS - 1);
          end
        end
        ST_GAP: begin
          if (sym_end) begin
            if (sym_left != '0) begin
              sym_left <= sym_left - SW'(1);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_engine.sv
// Self-checking bench for usb_tx_engine against a list-based packet model.
module tb_usb_tx_engine;

  localparam int FS_DIV     = 2;
  localparam int LS_DIV     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int IDLE_BITS  = 2;

  typedef logic [1:0] sym_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       low_speed;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [1:0] d_o;
  logic       d_en;
  logic       busy;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] cap_q[$];
  logic [1:0] cur_q[$];
  int len_q[$];
  int start_q[$];
  int gap_q[$];
  int wait_q[$];
  int first_acc;
  bit in_pkt = 1'b0;
  int idle_run = 0;

  usb_tx_engine #(
    .FS_DIV     (FS_DIV),
    .LS_DIV     (LS_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .IDLE_BITS  (IDLE_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .low_speed (low_speed),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .d_o       (d_o),
    .d_en      (d_en),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Line monitor: collects every d_en window as one packet.
  always @(negedge clk) begin
    if (reset) begin
      in_pkt = 1'b0;
      cur_q.delete();
      idle_run = 0;
    end else if (d_en) begin
      if (!in_pkt) begin
        in_pkt = 1'b1;
        start_q.push_back(int'(cyc));
        gap_q.push_back(idle_run);
      end
      cur_q.push_back(d_o);
    end else begin
      if (in_pkt) begin
        in_pkt = 1'b0;
        len_q.push_back(cur_q.size());
        foreach (cur_q[i]) cap_q.push_back(cur_q[i]);
        cur_q.delete();
        idle_run = 0;
      end
      idle_run++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pkt_len(input int idx);
    return (idx < len_q.size()) ? len_q[idx] : -1;
  endfunction

  function automatic int pkt_start(input int idx);
    return (idx < start_q.size()) ? start_q[idx] : -1;
  endfunction

  function automatic int pkt_gap(input int idx);
    return (idx < gap_q.size()) ? gap_q[idx] : -1;
  endfunction

  // Reference: SYNC + data bits LSB first, stuff after six 1s, NRZI from J, then SE0 SE0 J.
  task automatic build_exp(input byte_q_t bq, input bit ls, output sym_q_t ex);
    bit bits[$];
    bit line[$];
    int ones = 0;
    int div;
    logic [1:0] j, k, lvl;
    logic [7:0] b;
    b = 8'h80;
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    foreach (bq[n]) begin
      b = bq[n];
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    end
    foreach (bits[i]) begin
      line.push_back(bits[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line.push_back(1'b0);
        ones = 0;
      end
    end
    j   = ls ? 2'b01 : 2'b10;
    k   = ~j;
    div = ls ? LS_DIV : FS_DIV;
    lvl = j;
    ex.delete();
    foreach (line[i]) begin
      if (!line[i]) lvl = (lvl == j) ? k : j;
      repeat (div) ex.push_back(lvl);
    end
    repeat (2 * div) ex.push_back(2'b00);
    repeat (div) ex.push_back(j);
  endtask

  task automatic check_pkt(input string tag, input int idx, input sym_q_t ex);
    int off = 0;
    int len;
    int bad = -1;
    int last;
    len = pkt_len(idx);
    check_eq({tag, "_len"}, len, ex.size());
    if (len <= 0) return;
    for (int i = 0; i < idx; i++) off += len_q[i];
    last = (len < ex.size()) ? len : ex.size();
    for (int i = 0; i < last; i++)
      if (bad < 0 && cap_q[off + i] !== ex[i]) bad = i;
    if (bad < 0) bad = last - 1;
    check_eq($sformatf("%s_wave@%0d", tag, bad), cap_q[off + bad], ex[bad]);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    cap_q.delete();
    len_q.delete();
    start_q.delete();
    gap_q.delete();
    @(negedge clk);
  endtask

  // Called just after a negedge; each byte transfers on the posedge following a ready negedge.
  task automatic push_bytes(input byte_q_t bq);
    int n;
    wait_q.delete();
    foreach (bq[i]) begin
      n = 0;
      valid = 1'b1;
      data  = bq[i];
      while (!ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check_eq($sformatf("push%0d_in_time", i), n < 3000, 1);
      wait_q.push_back(n);
      @(negedge clk);
      if (i == 0) first_acc = int'(cyc);
    end
    valid = 1'b0;
  endtask

  task automatic wait_pkts(input string tag, input int cnt, input int budget);
    int n = 0;
    while (!(len_q.size() >= cnt && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, n < budget, 1);
  endtask

  task automatic run_pkt(input string tag, input byte_q_t bq, input bit ls);
    sym_q_t ex;
    clear_mon();
    low_speed = ls;
    push_bytes(bq);
    wait_pkts(tag, 1, 6000);
    build_exp(bq, ls, ex);
    check_pkt(tag, 0, ex);
    check_eq({tag, "_start"}, pkt_start(0), first_acc + 1);
    check_eq({tag, "_idle_den"}, d_en, 0);
    check_eq({tag, "_idle_do"}, d_o, ls ? 2'b01 : 2'b10);
  endtask

  initial begin
    byte_q_t bq;
    sym_q_t  ex;
    int n;

    reset = 1'b1;
    valid = 1'b0;
    data = 8'h00;
    low_speed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_den", d_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_do", d_o, 2'b10);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", ready, 1);

    bq = '{8'h00};
    run_pkt("t1_fs00", bq, 1'b0);
    check_eq("t1_len38", pkt_len(0), 38);

    bq = '{8'hFF};
    run_pkt("t2_fsff", bq, 1'b0);
    check_eq("t2_len40", pkt_len(0), 40);

    bq = '{8'h00};
    run_pkt("t3_ls00", bq, 1'b1);
    check_eq("t3_len304", pkt_len(0), 304);

    // Backpressure: six bytes offered back to back into a four-deep FIFO.
    clear_mon();
    low_speed = 1'b0;
    bq = '{8'h3C, 8'hFF, 8'h01, 8'hFC, 8'h80, 8'h7E};
    push_bytes(bq);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t4_ready_acc%0d", i), wait_q[i], 0);
    check_eq("t4_ready_drop", wait_q[4] > 0, 1);
    wait_pkts("t4", 1, 6000);
    build_exp(bq, 1'b0, ex);
    check_pkt("t4_bp", 0, ex);

    // Reset in the middle of the second data byte.
    clear_mon();
    low_speed = 1'b0;
    bq = '{8'h11, 8'h22, 8'h33};
    push_bytes(bq);
    n = 0;
    while (!d_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_started", n < 100, 1);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t5_ready_in_rst", ready, 0);
    @(negedge clk);
    check_eq("t5_den_after_rst", d_en, 0);
    check_eq("t5_busy_after_rst", busy, 0);
    reset = 1'b0;
    #1;
    check_eq("t5_ready_after_rst", ready, 1);
    bq = '{8'hA5};
    run_pkt("t5_clean", bq, 1'b0);

    // low_speed flips mid-packet; the queued next packet picks up LS.
    clear_mon();
    low_speed = 1'b0;
    bq = '{8'h12, 8'h34};
    push_bytes(bq);
    low_speed = 1'b1;
    n = 0;
    while (!(d_en && d_o == 2'b00) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_eop_seen", n < 2000, 1);
    bq = '{8'h56};
    push_bytes(bq);
    wait_pkts("t6", 2, 6000);
    bq = '{8'h12, 8'h34};
    build_exp(bq, 1'b0, ex);
    check_pkt("t6_fs", 0, ex);
    bq = '{8'h56};
    build_exp(bq, 1'b1, ex);
    check_pkt("t6_ls", 1, ex);
    check_eq("t6_gap", pkt_gap(1) >= IDLE_BITS * FS_DIV, 1);

    for (int p = 0; p < 10; p++) begin
      int cnt;
      bit ls;
      cnt = $urandom_range(1, 6);
      ls  = 1'($urandom_range(0, 1));
      bq.delete();
      for (int i = 0; i < cnt; i++) begin
        case ($urandom_range(0, 3))
          0:       bq.push_back(8'hFF);
          1:       bq.push_back(8'hFC);
          default: bq.push_back(8'($urandom));
        endcase
      end
      run_pkt($sformatf("rnd%0d", p), bq, ls);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
